// File: rtl/macrocell_config_loader_pkg.sv
// Shared definitions for the macrocell configuration path: sizes,
// loader state encoding and the config_word field layout.
package macrocell_pkg;

  localparam int MACROCELL_CONFIG_BITS = 13;
  localparam int NUM_PRODUCT_TERMS = 5;
  localparam int NUM_LAB_SIGNALS = 88;
  localparam int NUM_MACROCELLS = 16;

  // config_word layout: macrocell bits low, product-term bits above
  localparam int MC_FIELD_LSB = 0;
  localparam int MC_FIELD_MSB = MACROCELL_CONFIG_BITS - 1;
  localparam int PT_FIELD_LSB = MACROCELL_CONFIG_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WRITE,
    ST_DONE
  } loader_state_e;

  function automatic int cfg_width(int npt, int nls);
    return MACROCELL_CONFIG_BITS + npt * nls;
  endfunction

  function automatic int pt_field_msb(int npt, int nls);
    return cfg_width(npt, nls) - 1;
  endfunction

endpackage

// File: rtl/macrocell_config_loader_if.sv
// Bitstream input handshake and configuration write bus of the loader.
// slave = loader side, master = bitstream source / config storage side.
interface macrocell_config_loader_if
  import macrocell_pkg::*;
#(
  parameter int CW = cfg_width(NUM_PRODUCT_TERMS, NUM_LAB_SIGNALS),
  parameter int AW = $clog2(NUM_MACROCELLS)
);

  logic          bit_in;
  logic          bit_valid;
  logic          bit_ready;
  logic [CW-1:0] config_word;
  logic [AW-1:0] config_address;
  logic          config_write;

  modport master (
    output bit_in,
    output bit_valid,
    input  bit_ready,
    input  config_word,
    input  config_address,
    input  config_write
  );

  modport slave (
    input  bit_in,
    input  bit_valid,
    output bit_ready,
    output config_word,
    output config_address,
    output config_write
  );

endinterface

// File: rtl/macrocell_config_loader_config_shift_register.sv
// Right-shifting deserializer: new bits enter at the MSB so an
// LSB-first stream lands in natural bit order.
module config_shift_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (shift_en) begin
      q_d = {bit_in, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/macrocell_config_loader.sv
// Serial loader: deserializes the bitstream into one word per
// macrocell and strobes it out with its address.
module macrocell_config_loader
  import macrocell_pkg::*;
#(
  parameter int num_lab_signals   = NUM_LAB_SIGNALS,
  parameter int num_product_terms = NUM_PRODUCT_TERMS,
  parameter int num_macrocells    = NUM_MACROCELLS
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  macrocell_config_loader_if.slave bus
);

  localparam int config_width =
    cfg_width(num_product_terms, num_lab_signals);
  localparam int addr_width =
    (num_macrocells > 1) ? $clog2(num_macrocells) : 1;
  localparam int CNT_W = $clog2(config_width);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(config_width - 1);
  localparam logic [addr_width-1:0] ADDR_LAST =
    addr_width'(num_macrocells - 1);

  loader_state_e           state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [addr_width-1:0]   addr_q, addr_d;
  logic [config_width-1:0] word_q, word_d;
  logic [addr_width-1:0]   waddr_q, waddr_d;
  logic [config_width-1:0] sr;
  logic                    sr_clear;
  logic                    shift_en;

  config_shift_register #(
    .WIDTH (config_width)
  ) u_sr (
    .clk      (clock),
    .clear    (sr_clear),
    .shift_en (shift_en),
    .bit_in   (bus.bit_in),
    .q        (sr)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    word_d   = word_q;
    waddr_d  = waddr_q;
    shift_en = 1'b0;
    sr_clear = !reset_n;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && !abort) begin
          state_d  = ST_SHIFT;
          cnt_d    = '0;
          addr_d   = '0;
          sr_clear = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (bus.bit_valid) begin
          shift_en = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_WRITE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WRITE: begin
        // the strobed word is retained so outputs hold between strobes
        word_d  = sr;
        waddr_d = addr_q;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (addr_q == ADDR_LAST) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_SHIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      waddr_q <= waddr_d;
    end
  end

  always_comb begin
    bus.bit_ready    = (state_q == ST_SHIFT);
    bus.config_write = (state_q == ST_WRITE);
    busy = (state_q == ST_SHIFT) || (state_q == ST_WRITE);
    done = (state_q == ST_DONE);
    bus.config_word    = bus.config_write ? sr : word_q;
    bus.config_address = bus.config_write ? addr_q : waddr_q;
  end

endmodule

// File: tb/tb_macrocell_config_loader.sv
// Bench for macrocell_config_loader: directed scenarios plus random
// passes compared against an address/word reference sequence.
module tb_macrocell_config_loader;
  import macrocell_pkg::*;

  localparam int NLS = 2;
  localparam int NPT = 5;
  localparam int NMC = 2;
  localparam int CW  = 23;
  localparam int AW  = 1;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy;
  logic done;

  macrocell_config_loader_if #(.CW(CW), .AW(AW)) bif ();

  macrocell_config_loader #(
    .num_lab_signals   (NLS),
    .num_product_terms (NPT),
    .num_macrocells    (NMC)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .bus     (bif)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass = 0;
  logic [CW-1:0] got_word[$];
  int got_addr[$];

  always @(negedge clock) begin
    if (bif.config_write === 1'b1) begin
      got_word.push_back(bif.config_word);
      got_addr.push_back(int'(bif.config_address));
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_bit(input logic b);
    bit acc;
    acc = 1'b0;
    bif.bit_in = b;
    bif.bit_valid = 1'b1;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clock);
      acc = (bif.bit_ready === 1'b1);
      tick();
    end
    if (!acc) check("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic send_word(input logic [CW-1:0] w, input int k,
                           input int gap_pct);
    for (int i = 0; i < CW; i++) begin
      if ($urandom_range(99) < gap_pct) begin
        bif.bit_valid = 1'b0;
        tick();
      end
      push_bit(w[i]);
    end
    bif.bit_valid = 1'b0;
    check("strobe", 64'(bif.config_write), 64'd1);
    check("strobe_addr", 64'(bif.config_address), 64'(k));
    check("strobe_word", 64'(bif.config_word), 64'(w));
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_pass(input logic [CW-1:0] w0,
                          input logic [CW-1:0] w1,
                          input int gap_pct);
    logic [CW-1:0] exp_word[$];
    int exp_addr[$];
    exp_word = '{w0, w1};
    exp_addr = '{0, 1};
    got_word.delete();
    got_addr.delete();
    do_start();
    check("start_ready", 64'(bif.bit_ready), 64'd1);
    check("start_busy", 64'(busy), 64'd1);
    send_word(w0, 0, gap_pct);
    send_word(w1, 1, gap_pct);
    tick();
    check("pass_done", 64'(done), 64'd1);
    check("pass_idle_busy", 64'(busy), 64'd0);
    check("strobe_count", 64'(got_word.size()), 64'(NMC));
    for (int i = 0; i < NMC; i++) begin
      check("seq_addr", 64'(got_addr[i]), 64'(exp_addr[i]));
      check("seq_word", 64'(got_word[i]), 64'(exp_word[i]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(bif.bit_ready), 64'd0);
    check({tag, "_write"}, 64'(bif.config_write), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_word"}, 64'(bif.config_word), 64'd0);
    check({tag, "_addr"}, 64'(bif.config_address), 64'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] wa;
    logic [CW-1:0] wb;
    bif.bit_in = 1'b0;
    bif.bit_valid = 1'b0;

    repeat (3) tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();
    check_all_zero("idle");

    run_pass(23'h2AAAAA, 23'h155555, 0);
    run_pass(23'h2AAAAA, 23'h155555, 100);

    for (int p = 0; p < 3; p++) begin
      wa = CW'($urandom);
      wb = CW'($urandom);
      run_pass(wa, wb, 30);
    end

    // abort partway through word 1
    wa = CW'($urandom);
    wb = CW'($urandom);
    got_word.delete();
    got_addr.delete();
    do_start();
    send_word(wa, 0, 0);
    for (int i = 0; i < 10; i++) push_bit(wb[i]);
    bif.bit_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(bif.bit_ready), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    for (int i = 0; i < 30; i++) begin
      bif.bit_valid = 1'b1;
      bif.bit_in = 1'($urandom);
      tick();
    end
    bif.bit_valid = 1'b0;
    check("abort_strobes", 64'(got_word.size()), 64'd1);
    check("abort_still_idle", 64'(busy), 64'd0);
    run_pass(CW'($urandom), CW'($urandom), 0);

    // reset during the write cycle of word 0
    wa = CW'($urandom);
    do_start();
    for (int i = 0; i < CW; i++) push_bit(wa[i]);
    bif.bit_valid = 1'b0;
    check("rst_pre_strobe", 64'(bif.config_write), 64'd1);
    reset_n = 1'b0;
    tick();
    check_all_zero("rst_write");
    reset_n = 1'b1;
    tick();
    run_pass(CW'($urandom), CW'($urandom), 20);

    // start from DONE while a bit is offered
    wa = CW'($urandom);
    wb = CW'($urandom);
    start = 1'b1;
    bif.bit_valid = 1'b1;
    bif.bit_in = 1'b1;
    @(negedge clock);
    check("done_start_noaccept", 64'(bif.bit_ready), 64'd0);
    tick();
    start = 1'b0;
    bif.bit_valid = 1'b0;
    check("restart_done", 64'(done), 64'd0);
    check("restart_ready", 64'(bif.bit_ready), 64'd1);
    send_word(wa, 0, 0);
    send_word(wb, 1, 0);
    tick();
    check("restart_pass_done", 64'(done), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/macrocell_config_loader.md
Name: macrocell_config_loader

Overview:
- Serial configuration loader that sits directly upstream of the macrocell model.
- Deserializes a bitstream into per-macrocell configuration words: 13 macrocell logic bits plus the product-term bits.
- Emits one word per macrocell with an address and a one-cycle write strobe.
- The per-macrocell configuration storage captures the word on the strobe and drives each macrocell's config_macrocell / config_product_terms inputs.

Parameters:
- num_lab_signals, 88, LAB signals per product term (2*36 + 16).
- num_product_terms, 5, product terms per macrocell.
- num_macrocells, 16, macrocells loaded per pass (one LAB).
- config_width, 13 + num_product_terms*num_lab_signals, bits per macrocell word (derived; not overridden).
- addr_width, clog2(num_macrocells), width of config_address (derived).

Ports:
- clock  input  1  single clock; all state changes on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  begin a load pass; sampled only in IDLE or DONE.
- abort  input  1  cancel the pass in progress; return to IDLE.
- bit_in  input  1  serial configuration bit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  loader accepts a bit this cycle.
- config_word  output  config_width  assembled word; bits [12:0] = macrocell bits, [config_width-1:13] = product-term bits.
- config_address  output  addr_width  macrocell index of config_word.
- config_write  output  1  one-cycle strobe; config_word and config_address are valid.
- busy  output  1  pass in progress (SHIFT or WRITE).
- done  output  1  all num_macrocells words written; held until the next start.

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE; bit count=0; address=0; shift register=0. Outputs: bit_ready=0, config_write=0, busy=0, done=0, config_word=0, config_address=0. Reset mid-pass discards the partial word; no write is issued.
- States: IDLE, SHIFT, WRITE, DONE.
- IDLE:
  - start=1 -> SHIFT; clear bit count, address and done.
- SHIFT:
  - bit_ready=1, busy=1.
  - A bit is accepted when bit_valid and bit_ready are both 1.
  - On accept, the shift register moves right one place and bit_in enters bit config_width-1. After config_width accepts, the first bit received sits in bit 0 (LSB-first stream).
  - The accept that completes the word (bit count reaches config_width-1) -> WRITE next cycle. Bit count resets to 0.
  - bit_valid=0: hold state; no shift.
- WRITE (exactly 1 cycle):
  - config_write=1, bit_ready=0, busy=1; config_word = shift register, config_address = current address.
  - If address == num_macrocells-1 -> DONE; otherwise address+1 -> SHIFT.
  - Bits presented during WRITE are not accepted (bit_ready=0); the source must hold them.
- DONE:
  - done=1, busy=0, bit_ready=0.
  - start=1 -> SHIFT; done clears in that same cycle; address=0.
- abort=1 in SHIFT or WRITE -> IDLE next cycle.
  - A write strobe already asserted in the current cycle stands; no further write occurs.
  - done stays 0. abort in IDLE or DONE has no effect.
  - abort and start together: abort wins.
- start while busy is ignored.
- config_word and config_address hold their last written values between strobes; the downstream stage captures them on config_write only.
- Latency:
  - Strobe for word k arrives 1 cycle after its final bit is accepted.
  - Minimum pass length = num_macrocells*(config_width+1) cycles from the first accept.
- Address never wraps within a pass; the increment after num_macrocells-1 does not occur.

Decomposition:
- Shared package macrocell_pkg holds:
  - constants MACROCELL_CONFIG_BITS=13, NUM_PRODUCT_TERMS=5, NUM_LAB_SIGNALS=88;
  - the loader state enum;
  - the bit-field positions of config_word, so the downstream storage and the macrocell model use the same layout.
- One natural sub-module: config_shift_register (width parameter, shift-enable, parallel output, synchronous clear). The FSM, counters and strobe stay in the top.

Test Plan (num_lab_signals=2, num_macrocells=2, config_width=23):
- Reset then idle -> all outputs 0, bit_ready=0; start pulse -> bit_ready=1, busy=1 next cycle.
- Stream 46 bits back-to-back; word 0 = 23'h2AAAAA, word 1 = 23'h155555, LSB first -> config_write high for exactly 1 cycle each: address 0 with 23'h2AAAAA, then address 1 with 23'h155555. done=1 on the cycle after the second strobe.
- Same stream with bit_valid low on every other cycle -> identical words and addresses; strobe count = 2.
- abort after 10 bits of word 1 -> IDLE next cycle, no further config_write, done=0. A following start reloads from address 0.
- reset_n=0 on the WRITE cycle of word 0 -> strobe suppressed from the next cycle, all outputs 0. start with a fresh stream -> word 0 is written correctly.
- In DONE, pulse start together with bit_valid=1 -> no bit accepted that cycle; done=0 next cycle and the next pass begins at address 0.
